// File: rtl/control_pkg.sv
// Shared encodings for the control unit and datapath: FSM states, forced ALU ops,
// and mux select codes.
package control_pkg;

  typedef enum logic [3:0] {
    S_RST = 4'd0,
    S_F1  = 4'd1,
    S_F2  = 4'd2,
    S_F3  = 4'd3,
    S_DEC = 4'd4,
    S_DP  = 4'd5,
    S_LSA = 4'd6,
    S_LDW = 4'd7,
    S_LDB = 4'd8,
    S_STD = 4'd9,
    S_STW = 4'd10,
    S_BL1 = 4'd11,
    S_BR  = 4'd12
  } state_t;

  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_PASSB = 5'b01101;
  localparam logic [4:0] OP_PASSA = 5'b10000;
  localparam logic [4:0] OP_INC4  = 5'b10001;

  localparam logic [1:0] MA_RN = 2'b00;
  localparam logic [1:0] MA_RD = 2'b01;
  localparam logic [1:0] MA_PC = 2'b10;

  localparam logic [1:0] MB_SHIFT = 2'b01;
  localparam logic [1:0] MB_MDR   = 2'b10;
  localparam logic [1:0] MB_ZERO  = 2'b11;

  localparam logic [2:0] MC_RD = 3'b000;
  localparam logic [2:0] MC_PC = 3'b001;
  localparam logic [2:0] MC_LR = 3'b100;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // IR[22] is the B bit of single data transfers
  function automatic logic [1:0] xfer_size(input logic byte_bit);
    return byte_bit ? SIZE_BYTE : SIZE_WORD;
  endfunction

endpackage

// File: rtl/cu_output_decoder.sv
// Moore output decode for the control unit: every control line is a function of
// the current state and the instruction register only.
module cu_output_decoder
  import control_pkg::*;
(
  input  state_t      state,
  input  logic [31:0] IR,
  output logic        FR_ld,
  output logic        RF_ld,
  output logic        IR_ld,
  output logic        MAR_ld,
  output logic        MDR_ld,
  output logic        R_W,
  output logic        MOV,
  output logic        SE,
  output logic [1:0]  size,
  output logic [1:0]  MA,
  output logic [1:0]  MB,
  output logic [2:0]  MC,
  output logic        MD,
  output logic        ME,
  output logic [4:0]  OP
);

  logic unused_ir;
  assign unused_ir = ^{IR[31:25], IR[21], IR[19:0]};

  always_comb begin
    FR_ld  = 1'b0;
    RF_ld  = 1'b0;
    IR_ld  = 1'b0;
    MAR_ld = 1'b0;
    MDR_ld = 1'b0;
    R_W    = 1'b0;
    MOV    = 1'b0;
    SE     = 1'b0;
    size   = '0;
    MA     = '0;
    MB     = '0;
    MC     = '0;
    MD     = 1'b0;
    ME     = 1'b0;
    OP     = '0;
    case (state)
      S_F1: begin
        MA = MA_PC; MD = 1'b1; OP = OP_PASSA; MAR_ld = 1'b1;
      end
      S_F2: begin
        MA = MA_PC; MD = 1'b1; OP = OP_INC4; MC = MC_PC; RF_ld = 1'b1;
      end
      S_F3: begin
        MOV = 1'b1; R_W = 1'b1; size = SIZE_WORD; IR_ld = 1'b1;
      end
      S_DP: begin
        // TST/TEQ/CMP/CMN only update flags
        MA = MA_RN; MB = MB_SHIFT; MC = MC_RD;
        FR_ld = IR[20];
        RF_ld = (IR[24:23] != 2'b10);
      end
      S_LSA: begin
        MA = MA_RN; MB = MB_SHIFT; MD = 1'b1; MAR_ld = 1'b1;
        OP = IR[23] ? OP_ADD : OP_SUB;
      end
      S_LDW: begin
        MOV = 1'b1; R_W = 1'b1; MDR_ld = 1'b1; size = xfer_size(IR[22]);
      end
      S_LDB: begin
        MB = MB_MDR; MD = 1'b1; OP = OP_PASSB; MC = MC_RD; RF_ld = 1'b1;
      end
      S_STD: begin
        MA = MA_RD; MD = 1'b1; OP = OP_PASSA; ME = 1'b1; MDR_ld = 1'b1;
      end
      S_STW: begin
        MOV = 1'b1; size = xfer_size(IR[22]);
      end
      S_BL1: begin
        MA = MA_PC; MD = 1'b1; OP = OP_PASSA; MC = MC_LR; RF_ld = 1'b1;
      end
      S_BR: begin
        MA = MA_PC; MB = MB_SHIFT; MD = 1'b1; OP = OP_ADD; MC = MC_PC; RF_ld = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Control unit top: state register and next-state logic; all control lines come
// from the combinational decoder so reset clears them without a clock edge.
module control_unit
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        MOC,
  input  logic        Cond,
  output logic        FR_ld,
  output logic        RF_ld,
  output logic        IR_ld,
  output logic        MAR_ld,
  output logic        MDR_ld,
  output logic        R_W,
  output logic        MOV,
  output logic        SE,
  output logic [1:0]  size,
  output logic [1:0]  MA,
  output logic [1:0]  MB,
  output logic [2:0]  MC,
  output logic        MD,
  output logic        ME,
  output logic [4:0]  OP,
  output logic [3:0]  state
);

  state_t cur;

  logic unused_ir;
  assign unused_ir = ^{IR[31:28], IR[23:0]};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cur <= S_RST;
    end else begin
      case (cur)
        S_RST: cur <= S_F1;
        S_F1:  cur <= S_F2;
        S_F2:  cur <= S_F3;
        S_F3:  cur <= MOC ? S_DEC : S_F3;
        S_DEC: begin
          // Unrecognised classes and failed conditions fall back to fetch
          if (!Cond)                    cur <= S_F1;
          else if (IR[27:26] == 2'b00)  cur <= S_DP;
          else if (IR[27:26] == 2'b01)  cur <= S_LSA;
          else if (IR[27:25] == 3'b101) cur <= IR[24] ? S_BL1 : S_BR;
          else                          cur <= S_F1;
        end
        S_DP:  cur <= S_F1;
        S_LSA: cur <= IR[20] ? S_LDW : S_STD;
        S_LDW: cur <= MOC ? S_LDB : S_LDW;
        S_LDB: cur <= S_F1;
        S_STD: cur <= S_STW;
        S_STW: cur <= MOC ? S_F1 : S_STW;
        S_BL1: cur <= S_BR;
        S_BR:  cur <= S_F1;
        default: cur <= S_RST;
      endcase
    end
  end

  assign state = cur;

  cu_output_decoder u_dec (
    .state  (cur),
    .IR     (IR),
    .FR_ld  (FR_ld),
    .RF_ld  (RF_ld),
    .IR_ld  (IR_ld),
    .MAR_ld (MAR_ld),
    .MDR_ld (MDR_ld),
    .R_W    (R_W),
    .MOV    (MOV),
    .SE     (SE),
    .size   (size),
    .MA     (MA),
    .MB     (MB),
    .MC     (MC),
    .MD     (MD),
    .ME     (ME),
    .OP     (OP)
  );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle vector table fed through a scoreboard queue,
// plus a hand-written asynchronous reset during a store wait.
module tb_control_unit;
  import control_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] IR = '0;
  logic        MOC = 1'b0;
  logic        Cond = 1'b0;
  logic        FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV, SE, MD, ME;
  logic [1:0]  size, MA, MB;
  logic [2:0]  MC;
  logic [4:0]  OP;
  logic [3:0]  state;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .MOC(MOC), .Cond(Cond),
    .FR_ld(FR_ld), .RF_ld(RF_ld), .IR_ld(IR_ld), .MAR_ld(MAR_ld), .MDR_ld(MDR_ld),
    .R_W(R_W), .MOV(MOV), .SE(SE), .size(size), .MA(MA), .MB(MB), .MC(MC),
    .MD(MD), .ME(ME), .OP(OP), .state(state)
  );

  // {FR,RF,IR,MAR,MDR}_ld, R_W, MOV, SE, size, MA, MB, MC, MD, ME, OP
  logic [23:0] outs;
  assign outs = {FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV, SE, size, MA, MB, MC, MD, ME, OP};

  localparam logic [23:0] E_ZERO  = 24'h0;
  localparam logic [23:0] E_F1    = {5'b00010, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 1'b1, 1'b0, 5'b10000};
  localparam logic [23:0] E_F2    = {5'b01000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b1, 1'b0, 5'b10001};
  localparam logic [23:0] E_F3    = {5'b00100, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 5'b00000};
  localparam logic [23:0] E_DPADD = {5'b11000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0, 5'b00000};
  localparam logic [23:0] E_DPCMP = {5'b10000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0, 5'b00000};
  localparam logic [23:0] E_LSAAD = {5'b00010, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'b000, 1'b1, 1'b0, 5'b00100};
  localparam logic [23:0] E_LSASB = {5'b00010, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'b000, 1'b1, 1'b0, 5'b00010};
  localparam logic [23:0] E_LDWW  = {5'b00001, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 5'b00000};
  localparam logic [23:0] E_LDWB  = {5'b00001, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 5'b00000};
  localparam logic [23:0] E_LDB   = {5'b01000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 3'b000, 1'b1, 1'b0, 5'b01101};
  localparam logic [23:0] E_STD   = {5'b00001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000, 1'b1, 1'b1, 5'b10000};
  localparam logic [23:0] E_STWW  = {5'b00000, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 5'b00000};
  localparam logic [23:0] E_STWB  = {5'b00000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 5'b00000};
  localparam logic [23:0] E_BL1   = {5'b01000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b100, 1'b1, 1'b0, 5'b10000};
  localparam logic [23:0] E_BR    = {5'b01000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b001, 1'b1, 1'b0, 5'b00100};

  localparam logic [31:0] I_ADDS = 32'hE0921003;
  localparam logic [31:0] I_CMP  = 32'hE1520003;
  localparam logic [31:0] I_LDR  = 32'hE5910004;
  localparam logic [31:0] I_LDRB = 32'hE5510004;  // byte load, U=0
  localparam logic [31:0] I_STRB = 32'hE5C10004;
  localparam logic [31:0] I_STR  = 32'hE5810004;
  localparam logic [31:0] I_BL   = 32'hEB000002;
  localparam logic [31:0] I_NOP  = 32'hEC000000;

  typedef struct {
    int          idx;
    logic [31:0] ir;
    logic        moc;
    logic        cond;
    logic [3:0]  st;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] ir, input logic moc, input logic cond,
                     input state_t st, input logic [23:0] exp);
    vec_t v;
    v.idx = tbl.size(); v.ir = ir; v.moc = moc; v.cond = cond; v.st = st; v.exp = exp;
    tbl.push_back(v);
  endtask

  // From F1: F2, F3, then DEC on MOC=1
  task automatic add_fetch(input logic [31:0] ir);
    add(ir, 1'b0, 1'b0, S_F2, E_F2);
    add(ir, 1'b0, 1'b0, S_F3, E_F3);
    add(ir, 1'b1, 1'b0, S_DEC, E_ZERO);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk($sformatf("vec%0d state", e.idx), {28'h0, state}, {28'h0, e.st});
      chk($sformatf("vec%0d outs", e.idx), {8'h0, outs}, {8'h0, e.exp});
    end
  end

  initial begin
    #2 clr = 1'b0;
    #2;
    chk("reset state", {28'h0, state}, 32'h0);
    chk("reset outs", {8'h0, outs}, 32'h0);

    // Fetch with F3 held three cycles; MOC/Cond outside their states ignored
    add(I_ADDS, 1'b0, 1'b0, S_F1, E_F1);
    add(I_ADDS, 1'b1, 1'b0, S_F2, E_F2);
    add(I_ADDS, 1'b1, 1'b1, S_F3, E_F3);
    add(I_ADDS, 1'b0, 1'b0, S_F3, E_F3);
    add(I_ADDS, 1'b0, 1'b0, S_F3, E_F3);
    add(I_ADDS, 1'b1, 1'b0, S_DEC, E_ZERO);
    add(I_ADDS, 1'b0, 1'b1, S_DP, E_DPADD);
    add(I_CMP, 1'b0, 1'b0, S_F1, E_F1);
    add_fetch(I_CMP);
    add(I_CMP, 1'b0, 1'b1, S_DP, E_DPCMP);
    add(I_LDR, 1'b0, 1'b0, S_F1, E_F1);
    add_fetch(I_LDR);
    add(I_LDR, 1'b0, 1'b1, S_LSA, E_LSAAD);
    add(I_LDR, 1'b1, 1'b0, S_LDW, E_LDWW);
    add(I_LDR, 1'b0, 1'b0, S_LDW, E_LDWW);
    add(I_LDR, 1'b1, 1'b0, S_LDB, E_LDB);
    add(I_LDR, 1'b0, 1'b0, S_F1, E_F1);
    add_fetch(I_LDRB);
    add(I_LDRB, 1'b0, 1'b1, S_LSA, E_LSASB);
    add(I_LDRB, 1'b0, 1'b0, S_LDW, E_LDWB);
    add(I_LDRB, 1'b1, 1'b0, S_LDB, E_LDB);
    add(I_LDRB, 1'b0, 1'b0, S_F1, E_F1);
    add_fetch(I_BL);
    add(I_BL, 1'b0, 1'b1, S_BL1, E_BL1);
    add(I_BL, 1'b0, 1'b0, S_BR, E_BR);
    add(I_BL, 1'b0, 1'b0, S_F1, E_F1);
    add_fetch(I_BL);
    add(I_BL, 1'b0, 1'b0, S_F1, E_F1);
    add_fetch(I_NOP);
    add(I_NOP, 1'b0, 1'b1, S_F1, E_F1);
    add_fetch(I_STRB);
    add(I_STRB, 1'b0, 1'b1, S_LSA, E_LSAAD);
    add(I_STRB, 1'b1, 1'b0, S_STD, E_STD);
    add(I_STRB, 1'b0, 1'b0, S_STW, E_STWB);
    add(I_STRB, 1'b0, 1'b0, S_STW, E_STWB);
    add(I_STRB, 1'b1, 1'b0, S_F1, E_F1);
    add_fetch(I_STR);
    add(I_STR, 1'b0, 1'b1, S_LSA, E_LSAAD);
    add(I_STR, 1'b0, 1'b0, S_STD, E_STD);
    add(I_STR, 1'b0, 1'b0, S_STW, E_STWW);
    add(I_STR, 1'b0, 1'b0, S_STW, E_STWW);

    @(negedge clk);
    clr = 1'b1;
    foreach (tbl[i]) begin
      IR = tbl[i].ir;
      MOC = tbl[i].moc;
      Cond = tbl[i].cond;
      sb.push_back(tbl[i]);
      @(negedge clk);
    end
    chk("scoreboard drained", sb.size(), 32'h0);

    // Reset mid store wait must drop MOV without an edge
    chk("STW MOV before reset", {31'h0, MOV}, 32'h1);
    #1 clr = 1'b0;
    #1;
    chk("async reset state", {28'h0, state}, 32'h0);
    chk("async reset MOV", {31'h0, MOV}, 32'h0);
    chk("async reset outs", {8'h0, outs}, 32'h0);
    @(posedge clk);
    #1;
    chk("reset held state", {28'h0, state}, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    MOC = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset state", {28'h0, state}, {28'h0, S_F1});
    chk("post-reset outs", {8'h0, outs}, {8'h0, E_F1});
    @(posedge clk);
    #1;
    chk("post-reset F2 state", {28'h0, state}, {28'h0, S_F2});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
